// File: rtl/lcd_text_fetch.sv
// lcd_text_fetch: raster timing generator and text-screen fetch for the LCD renderer.
//
// Runs the panel raster from PixelClk and looks up a COLS x ROWS text screen held in
// a 1024x8 block RAM that the CPU writes. For every pixel it presents the
// character code and the row/column inside the glyph, plus a data-enable, to the
// font/pixel stage. All outputs come from the same register stage. They describe the
// raster position of two clocks earlier.
//
// Ports:
//   PixelClk    pixel clock, the only clock
//   nRST        asynchronous active-low reset
//   WrEn        CPU write strobe
//   WrAddr      text cell address (row*COLS+col). Addresses >= COLS*ROWS are ignored.
//   WrData      character code to store
//   Character   character code of the current pixel (0 when PixDE=0)
//   GlyphRow    pixel row inside the glyph (0 when PixDE=0)
//   GlyphCol    pixel column inside the glyph (0 when PixDE=0)
//   PixDE       high for visible pixels
//   FrameStart  one-cycle pulse aligned to the first raster position of a frame

module lcd_text_fetch #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_BACK   = 43,
    parameter int unsigned H_FRONT  = 8,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_BACK   = 12,
    parameter int unsigned V_FRONT  = 8,
    parameter int unsigned CHAR_W   = 8,
    parameter int unsigned CHAR_H   = 16,
    parameter int unsigned COLS     = H_ACTIVE / CHAR_W,
    parameter int unsigned ROWS     = V_ACTIVE / CHAR_H
) (
    input  logic                      PixelClk,
    input  logic                      nRST,
    input  logic                      WrEn,
    input  logic [9:0]                WrAddr,
    input  logic [7:0]                WrData,
    output logic [7:0]                Character,
    output logic [$clog2(CHAR_H)-1:0] GlyphRow,
    output logic [$clog2(CHAR_W)-1:0] GlyphCol,
    output logic                      PixDE,
    output logic                      FrameStart
);

    localparam int unsigned H_TOTAL = H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned RW      = $clog2(CHAR_H);
    localparam int unsigned CW      = $clog2(CHAR_W);
    localparam int unsigned AW      = 10;

    localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_START = HW'(H_BACK);
    localparam logic [HW-1:0] H_END   = HW'(H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(V_BACK);
    localparam logic [VW-1:0] V_END   = VW'(V_BACK + V_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_BACK + V_ACTIVE - 1);
    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
    localparam logic [AW-1:0] CELLS_A = AW'(COLS * ROWS);

    // ---------------- Stage 0: raster counters and read address ----------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] row_base;

    logic          h_vis, v_vis, vis0;
    logic          line_end, frame_end, frame0;
    logic [HW-1:0] x;
    logic [RW-1:0] y_low;
    logic [AW-1:0] rd_addr;

    always_comb begin
        h_vis     = (h_cnt >= H_START) && (h_cnt < H_END);
        v_vis     = (v_cnt >= V_START) && (v_cnt < V_END);
        vis0      = h_vis && v_vis;
        line_end  = (h_cnt == H_MAX);
        frame_end = line_end && (v_cnt == V_MAX);
        frame0    = (h_cnt == '0) && (v_cnt == '0);
        x         = h_cnt - H_START;
        y_low     = RW'(v_cnt - V_START);
        rd_addr   = row_base + AW'(x >> CW);
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // row_base tracks (y / CHAR_H) * COLS: it steps after the last glyph line
            // of each text row, except the final one, so it never leaves the screen.
            if (frame_end) begin
                row_base <= '0;
            end else if (line_end && v_vis && (&y_low) && (v_cnt != V_LAST)) begin
                row_base <= row_base + COLS_A;
            end
        end
    end

    // ---------------- Stage 1: text RAM read, side-band delay ----------------
    logic [7:0]    mem [1024];
    logic [7:0]    rd_data;
    logic          vis1, frame1;
    logic [RW-1:0] grow1;
    logic [CW-1:0] gcol1;

    // Write port kept free of reset so the array maps onto a block RAM.
    always_ff @(posedge PixelClk) begin
        if (WrEn && (WrAddr < CELLS_A)) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Non-blocking read of the array gives read-first behaviour on a same-address write.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            vis1   <= 1'b0;
            frame1 <= 1'b0;
            grow1  <= '0;
            gcol1  <= '0;
        end else begin
            vis1   <= vis0;
            frame1 <= frame0;
            grow1  <= y_low;
            gcol1  <= x[CW-1:0];
        end
    end

    // ---------------- Stage 2: registered outputs ----------------
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            Character  <= '0;
            GlyphRow   <= '0;
            GlyphCol   <= '0;
            PixDE      <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            Character  <= vis1 ? rd_data : '0;
            GlyphRow   <= vis1 ? grow1 : '0;
            GlyphCol   <= vis1 ? gcol1 : '0;
            PixDE      <= vis1;
            FrameStart <= frame1;
        end
    end

endmodule

// File: tb/tb_lcd_text_fetch.sv
// Bench for lcd_text_fetch, run with a shrunken raster (72x52 clocks per frame)
// so several whole frames fit in a short run. The reference model maps an absolute
// raster position to the expected pixel with plain division and modulo.

module tb_lcd_text_fetch;

    localparam int H_ACTIVE = 64;
    localparam int H_BACK   = 5;
    localparam int H_FRONT  = 3;
    localparam int V_ACTIVE = 48;
    localparam int V_BACK   = 2;
    localparam int V_FRONT  = 2;
    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int COLS     = H_ACTIVE / CHAR_W;
    localparam int ROWS     = V_ACTIVE / CHAR_H;
    localparam int CELLS    = COLS * ROWS;
    localparam int HT       = H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT       = V_BACK + V_ACTIVE + V_FRONT;
    localparam int FT       = HT * VT;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] Character;
    logic [3:0] GlyphRow;
    logic [2:0] GlyphCol;
    logic       PixDE;
    logic       FrameStart;

    always #5 clk = ~clk;

    lcd_text_fetch #(
        .H_ACTIVE (H_ACTIVE),
        .H_BACK   (H_BACK),
        .H_FRONT  (H_FRONT),
        .V_ACTIVE (V_ACTIVE),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT),
        .CHAR_W   (CHAR_W),
        .CHAR_H   (CHAR_H)
    ) dut (
        .PixelClk   (clk),
        .nRST       (rst_n),
        .WrEn       (wr_en),
        .WrAddr     (wr_addr),
        .WrData     (wr_data),
        .Character  (Character),
        .GlyphRow   (GlyphRow),
        .GlyphCol   (GlyphCol),
        .PixDE      (PixDE),
        .FrameStart (FrameStart)
    );

    typedef struct packed {
        int         pos;
        logic [7:0] ch;
        logic [3:0] gr;
        logic [2:0] gc;
        logic       de;
        logic       fs;
    } exp_t;

    logic [7:0] mem_m [1024];

    // Expected outputs for absolute raster position p, reading the screen as it is now.
    function automatic exp_t model_at(int p);
        exp_t e;
        int f, h, v, x, y;
        e     = '0;
        e.pos = p;
        f     = p % FT;
        h     = f % HT;
        v     = f / HT;
        e.fs  = (f == 0);
        if (h >= H_BACK && h < H_BACK + H_ACTIVE && v >= V_BACK && v < V_BACK + V_ACTIVE) begin
            x    = h - H_BACK;
            y    = v - V_BACK;
            e.de = 1'b1;
            e.ch = mem_m[(y / CHAR_H) * COLS + x / CHAR_W];
            e.gr = 4'(y % CHAR_H);
            e.gc = 3'(x % CHAR_W);
        end
        return e;
    endfunction

    // cyc counts rising edges since reset release; the edge numbered n reads position n-1,
    // and the outputs after the following edge show it.
    int   cyc = 0;
    exp_t exp_cur, exp_next;

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc         = 0;
            exp_cur     = '0;
            exp_cur.pos = -1;
            exp_next    = exp_cur;
        end else begin
            exp_cur  = exp_next;
            exp_next = model_at(cyc);
            cyc++;
        end
        if (wr_en && int'(wr_addr) < CELLS) mem_m[wr_addr] = wr_data;
    end

    int n_cmp    = 0;
    int n_fail   = 0;
    bit lit_on   = 1'b1;
    int mcyc     = 0;
    int last_fs  = -1;
    int de_cnt   = 0;
    int first_de = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, got, want);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] ch, input logic [3:0] gr,
                       input logic [2:0] gc);
        check(name, {17'd0, Character, GlyphRow, GlyphCol}, {17'd0, ch, gr, gc});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {15'd0, Character, GlyphRow, GlyphCol, PixDE, FrameStart}, 32'd0);
            last_fs  = -1;
            de_cnt   = 0;
            first_de = -1;
        end else begin
            check($sformatf("pixel pos=%0d", exp_cur.pos),
                  {15'd0, Character, GlyphRow, GlyphCol, PixDE, FrameStart},
                  {15'd0, exp_cur.ch, exp_cur.gr, exp_cur.gc, exp_cur.de, exp_cur.fs});
            mcyc++;
            if (PixDE) begin
                de_cnt++;
                if (first_de < 0) first_de = mcyc;
            end
            if (FrameStart) begin
                if (last_fs >= 0) begin
                    check("frame_period", mcyc - last_fs, 3744);
                    check("de_per_frame", de_cnt, 3072);
                    check("first_de_offset", first_de - last_fs, 149);
                end
                last_fs  = mcyc;
                de_cnt   = 0;
                first_de = -1;
            end
            if (lit_on) begin
                case (exp_cur.pos)
                    149:          lit("pix_0_0", 8'h41, 4'd0, 3'd0);
                    1229:         lit("pix_0_15", 8'h41, 4'd15, 3'd0);
                    1592:         lit("pix_3_20", 8'h55, 4'd4, 3'd3);
                    1596:         lit("pix_7_20", 8'h55, 4'd4, 3'd7);
                    1597:         lit("pix_8_20", 8'h20, 4'd4, 3'd0);
                    3596:         lit("pix_63_47", 8'h42, 4'd15, 3'd7);
                    FT + 1592:    lit("read_first_old", 8'h55, 4'd4, 3'd3);
                    2 * FT + 1592: lit("read_first_new", 8'h33, 4'd4, 3'd3);
                    2 * FT + 1593: lit("next_pix_new", 8'h33, 4'd4, 3'd4);
                    default: ;
                endcase
            end
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 10'(a);
        wr_data = d;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout @%0t: got no end of run, want end of run", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Screen set-up, all done before the first visible pixel.
        for (int i = 0; i < CELLS; i++) wr(i, 8'h20);
        wr(0, 8'h41);
        wr(CELLS - 1, 8'h42);
        wr(COLS, 8'h55);
        wr(CELLS, 8'h7E);
        wr(1020, 8'h7E);
        wr_en = 1'b0;

        // Write into the cell being read on the very same edge.
        wait_cyc(FT + 1592);
        wr_en   = 1'b1;
        wr_addr = 10'(COLS);
        wr_data = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;

        // Random CPU traffic across two frames, mostly to valid cells.
        wait_cyc(2 * FT + 2000);
        while (cyc < 4 * FT) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, CELLS - 1))
                                                  : 10'($urandom_range(0, 1023));
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Reset in the middle of a frame, then let the raster restart.
        wait_cyc(4 * FT + 30 * HT + 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        lit_on = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(FT + 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
